// File: rtl/spimastertx.sv
// spimastertx - 16-bit CS/SCL/MOSI frame transmitter with a one-word holding
// register, for the FPGA SPI slave receivers.
//
// Each frame is framed by SCL periods with CS low on both sides. The leading
// one resets the slave's bit counter. The trailing one is the slave's capture
// edge. When a word is waiting at the end of the trailing period, that period
// also serves as the next frame's leading period, so back-to-back frames cost
// 17 SCL periods instead of 18.
//
// Parameters:
//   CLKDIV  clk cycles per SCL half-period (2..255)
//
// Ports:
//   clk     system clock, all logic on posedge
//   resetq  asynchronous active-low reset
//   tx      word to send, sampled when wr=1
//   wr      single-cycle write strobe
//   busy    frame in progress or holding register full (registered)
//   ovf     sticky overrun flag: a write landed on a full holding register
//   CS      frame select, active high (registered)
//   SCL     serial clock, idles low (registered)
//   MOSI    serial data, MSB first (registered)

module spimastertx #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [15:0] tx,
  input  logic        wr,
  output logic        busy,
  output logic        ovf,
  output logic        CS,
  output logic        SCL,
  output logic        MOSI
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  localparam logic [7:0] PHASE_LAST = 8'(CLKDIV - 1);

  logic [1:0]  state, state_d;
  logic [15:0] hold;
  logic        full, full_d;
  logic [15:0] shift, shift_d;
  logic [7:0]  phase, phase_d;
  logic [3:0]  bitcnt, bitcnt_d;
  logic        ovf_d, busy_d, cs_d, scl_d, mosi_d;

  logic        half_end;    // last clk cycle of the current SCL half
  logic        period_end;  // last clk cycle of the high half
  logic        consume;     // FSM takes the holding word this cycle
  logic [3:0]  bit_next;
  logic [3:0]  bit_idx;

  assign half_end   = (phase == PHASE_LAST);
  assign period_end = half_end && SCL;
  assign consume    = full && ((state == ST_IDLE) ||
                               (state == ST_TRAIL && period_end));
  // The bit counter wraps 15 -> 0, and that wrap is the SHIFT exit.
  assign bit_next   = bitcnt + 4'd1;
  assign bit_idx    = 4'd15 - bit_next;

  // NOTE: every signal this block assigns gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    shift_d  = shift;
    phase_d  = phase;
    bitcnt_d = bitcnt;
    cs_d     = CS;
    scl_d    = SCL;
    mosi_d   = MOSI;

    if (state == ST_IDLE) begin
      phase_d = '0;
      scl_d   = 1'b0;
      cs_d    = 1'b0;
      mosi_d  = 1'b0;
      if (full) begin
        shift_d = hold;
        state_d = ST_LEAD;
      end
    end else begin
      if (half_end) begin
        phase_d = '0;
        scl_d   = ~SCL;
      end else begin
        phase_d = phase + 8'd1;
      end

      // CS and MOSI move only together with the SCL falling edge, which
      // gives a full low half of setup before the slave's rising edge.
      if (period_end) begin
        case (state)
          ST_LEAD: begin
            state_d  = ST_SHIFT;
            bitcnt_d = '0;
            cs_d     = 1'b1;
            mosi_d   = shift[15];
          end
          ST_SHIFT: begin
            bitcnt_d = bit_next;
            if (bitcnt == 4'd15) begin
              state_d = ST_TRAIL;
              cs_d    = 1'b0;
              mosi_d  = 1'b0;
            end else begin
              mosi_d  = shift[bit_idx];
            end
          end
          default: begin  // ST_TRAIL
            if (full) begin
              // This trailing period already gave the slave its
              // counter-reset edge, so skip LEAD.
              state_d  = ST_SHIFT;
              shift_d  = hold;
              bitcnt_d = '0;
              cs_d     = 1'b1;
              mosi_d   = hold[15];
            end else begin
              state_d  = ST_IDLE;
              cs_d     = 1'b0;
              mosi_d   = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Holding register flags. A write on the consume cycle refills the
  // register the FSM is emptying, so it is not an overrun.
  always_comb begin
    full_d = full;
    ovf_d  = ovf;
    if (wr) begin
      full_d = 1'b1;
      if (full && !consume) begin
        ovf_d = 1'b1;
      end
    end else if (consume) begin
      full_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE) || full_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state  <= ST_IDLE;
      full   <= 1'b0;
      shift  <= '0;
      phase  <= '0;
      bitcnt <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      CS     <= 1'b0;
      SCL    <= 1'b0;
      MOSI   <= 1'b0;
    end else begin
      state  <= state_d;
      full   <= full_d;
      shift  <= shift_d;
      phase  <= phase_d;
      bitcnt <= bitcnt_d;
      ovf    <= ovf_d;
      busy   <= busy_d;
      CS     <= cs_d;
      SCL    <= scl_d;
      MOSI   <= mosi_d;
    end
  end

  // NOTE: the holding data has no reset; it is never read unless full=1,
  // and full is reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      hold <= tx;
    end
  end

endmodule

// File: doc/spimastertx.md
Name: spimastertx

Overview:
- SPI-style 16-bit frame transmitter, the sending end of the CS/SCL/MOSI link used by our FPGA SPI slave receivers.
- Takes words from the J1 I/O bus in the `clk` domain and generates CS, SCL and MOSI so the receiving slave captures each word exactly once.
- A one-word holding register allows back-to-back frames. On overrun the newest word wins, because stale data is worthless in this application.

Parameters:
- CLKDIV, 4, `clk` cycles per SCL half-period; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetq  in  1  asynchronous active-low reset.
- tx  in  16  word to send.
- wr  in  1  single-cycle write strobe; `tx` is sampled when wr=1.
- busy  out  1  high while a frame is in progress or the holding register is full.
- ovf  out  1  sticky overrun flag; set when wr arrives with the holding register full.
- CS  out  1  frame select, active high; registered.
- SCL  out  1  serial clock, idles low; registered.
- MOSI  out  1  serial data, MSB first; registered.

Behaviour:
- Reset (async, resetq=0):
  - State is IDLE, holding register empty, shift register = 0, phase counter = 0.
  - CS=0, SCL=0, MOSI=0, busy=0, ovf=0.
  - Reset mid-frame aborts immediately to these values; the slave discards the partial word because its bit counter never wraps.
- Slave contract:
  - The slave samples CS and MOSI on SCL rising edges.
  - It needs at least one edge with CS=0 before the frame, then exactly 16 edges with CS=1, then at least one further edge.
  - Its capture happens on that trailing edge.
- Bit timing:
  - Each SCL period is 2*CLKDIV clk cycles: a low half, then a high half.
  - CS and MOSI change only at the start of a low half (SCL falling or idle), so each is stable for CLKDIV cycles before the rising edge.
- Holding register:
  - wr=1 with holding empty: load `tx` into holding, mark full.
  - wr=1 with holding full: overwrite holding with `tx` and set ovf=1. ovf is cleared only by reset.
  - wr on the same cycle the FSM consumes holding: the consumed word is the old holding value, the new word is loaded, holding stays full, and ovf is not set.
- FSM states:
  - IDLE: SCL=0, CS=0. If holding is full, move holding into the shift register, clear full, and go to LEAD next cycle.
  - LEAD: one SCL period with CS=0, MOSI=0. Provides the slave counter-reset edge. Then go to SHIFT.
  - SHIFT: 16 SCL periods with CS=1.
    - At the start of period n (n=0..15), MOSI = shift[15-n].
    - A 4-bit bit counter counts rising edges; after the 16th period, go to TRAIL.
  - TRAIL: one SCL period with CS=0, MOSI=0; the slave capture edge happens here. At the end of TRAIL:
    - holding full: load the shift register, clear full, go to SHIFT directly. TRAIL doubles as the next LEAD.
    - otherwise: go to IDLE.
- Frame length:
  - Isolated frame: 18 SCL periods = 36*CLKDIV cycles from LEAD entry back to IDLE.
  - Back-to-back frames: 17 periods each.
- busy = (state != IDLE) or holding full. It is registered, so it asserts the cycle after wr.
- Width rules:
  - The phase counter is 8 bits and wraps at CLKDIV-1.
  - The bit counter is 4 bits and wraps 15 to 0, which is the exit condition from SHIFT.

Test Plan:
- CLKDIV=2; wr with tx=16'hA55A from idle -> exactly 18 SCL rising edges. CS=0 on the first, CS=1 on edges 2..17 with MOSI=1,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0, CS=0 on edge 18. busy is high for 72 cycles plus 2 of latency, and a model slave captures 16'hA55A.
- Back-to-back: wr 16'h1234, then wr 16'hBEEF during SHIFT -> the second frame starts directly after TRAIL (17 periods, no extra LEAD). The slave captures 16'h1234 then 16'hBEEF; ovf=0.
- Overrun: wr 16'h0001 (starts frame), wr 16'h0002, wr 16'h0003 within the same frame -> frames carry 16'h0001 then 16'h0003 only, and ovf=1 sticky afterwards.
- Same-cycle consume and write: wr asserted exactly in the last TRAIL cycle while holding is full -> the old holding word is sent, the new word is sent next, and ovf stays 0.
- Reset mid-SHIFT after 7 bits -> CS, SCL, MOSI, busy and ovf are all 0 asynchronously. The model slave latches no word, and the next wr of 16'hFFFF is received intact.
- CLKDIV=5 -> SCL high and low halves are each exactly 5 cycles, and MOSI/CS never change while SCL=1.
